// File: rtl/uart_rx_if.sv
// UART receiver bundle: serial line in, recovered byte and strobes out.
interface uart_rx_if;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        input  rx_in,
        output rx_data, rx_done, frame_err, rx_busy
    );

    modport slave (
        output rx_in,
        input  rx_data, rx_done, frame_err, rx_busy
    );
endinterface

// File: rtl/uart_rx_block.sv
// 8N1 UART receiver: 2-flop sync, 3-point majority vote per bit,
// one-cycle rx_done / frame_err strobes in the system clock domain.
module uart_rx_block #(
    parameter int CLK_FREQ  = 44,
    parameter int BAUD_RATE = 115200
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.master rx
);
    localparam int N  = CLK_FREQ * 1_000_000 / BAUD_RATE;
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);

    // START counts from E; later bits count from the previous decision.
    localparam logic [CW-1:0] ST_LO = CW'(H - 2);
    localparam logic [CW-1:0] ST_MD = CW'(H - 1);
    localparam logic [CW-1:0] ST_HI = CW'(H);
    localparam logic [CW-1:0] BT_LO = CW'(N - 3);
    localparam logic [CW-1:0] BT_MD = CW'(N - 2);
    localparam logic [CW-1:0] BT_HI = CW'(N - 1);

    if (N < 8) begin : g_bad_n
        $error("uart_rx_block: N must be at least 8");
    end

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, WAIT_IDLE
    } state_e;

    state_e        state_q, state_d;
    logic          sync1_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          s1_q, s1_d, s2_q, s2_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          active, in_start;
    logic          lo_hit, md_hit, hi_hit, vote;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= rx.rx_in;
            rx_s_q  <= sync1_q;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        in_start = (state_q == START);
        active   = in_start || state_q == DATA || state_q == STOP;
        lo_hit = active && cnt_q == (in_start ? ST_LO : BT_LO);
        md_hit = active && cnt_q == (in_start ? ST_MD : BT_MD);
        hi_hit = active && cnt_q == (in_start ? ST_HI : BT_HI);
        vote = (s1_q & s2_q) | (s1_q & rx_s_q) | (s2_q & rx_s_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (!rx_s_q) state_d = START;
            START:     if (hi_hit) state_d = vote ? IDLE : DATA;
            DATA:      if (hi_hit && idx_q == 3'd7) state_d = STOP;
            STOP:      if (hi_hit) state_d = vote ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s_q) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        idx_d  = idx_q;
        sh_d   = sh_q;
        s1_d   = lo_hit ? rx_s_q : s1_q;
        s2_d   = md_hit ? rx_s_q : s2_q;
        data_d = data_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        busy_d = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
            end
            START: if (hi_hit) cnt_d = '0;
            DATA: if (hi_hit) begin
                cnt_d = '0;
                sh_d  = {vote, sh_q[7:1]};
                idx_d = idx_q + 3'd1;
            end
            STOP: if (hi_hit) begin
                cnt_d = '0;
                if (vote) begin
                    data_d = sh_q;
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            WAIT_IDLE: cnt_d = '0;
            default:   cnt_d = '0;
        endcase
    end

    assign rx.rx_data   = data_q;
    assign rx.rx_done   = done_q;
    assign rx.frame_err = err_q;
    assign rx.rx_busy   = busy_q;
endmodule
